// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the divided-clock meter.
package clk_meter_pkg;

  // Measurement FSM: wait for an edge, discard the first partial period, then report.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

  // Counter value at which a missing rising edge is declared a loss of input.
  function automatic int unsigned cnt_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Input synchronizer plus history flop producing registered rise/fall strobes.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift the raw input through the synchronizer and compare against the history flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  // Synchronizer, history and strobe registers; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // lvl is the history flop, so it already reflects the edge that rise/fall announce.
  assign lvl  = hist_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clk_div_meter.sv
// Measures period and high time of a slow (possibly asynchronous) signal in clk cycles.
module clk_div_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntSat = CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] base_period_q, base_period_d;
  logic [CNT_W-1:0] base_high_q, base_high_d;
  logic             mv_q, mv_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic edge_lvl;
  logic edge_rise;
  logic edge_fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .lvl   (edge_lvl),
    .rise  (edge_rise),
    .fall  (edge_fall)
  );

  // The strobes and the delayed level come from the same flops and must never disagree.
  a_edge_lvl: assert property (@(posedge clk) disable iff (rst)
    !(edge_rise && !edge_lvl) && !(edge_fall && edge_lvl));

  // FSM, saturating counter, high-time latch, reporting and lock comparison.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_lat_d      = hi_lat_q;
    period_d      = period_q;
    high_d        = high_q;
    base_period_d = base_period_q;
    base_high_d   = base_high_q;
    mv_d          = 1'b0;
    locked_d      = locked_q;
    timeout_d     = timeout_q;
    cnt_inc       = (cnt_q == CntSat) ? cnt_q : cnt_q + CntOne;

    unique case (state_q)
      IDLE: begin
        if (edge_rise) begin
          cnt_d   = CntOne;
          state_d = FIRST;
        end
      end
      FIRST, MEASURE: begin
        if (edge_rise) begin
          cnt_d = CntOne;
          if (state_q == FIRST) begin
            // The first full period is silent but seeds the lock comparison.
            state_d = MEASURE;
          end else begin
            period_d  = cnt_q;
            high_d    = hi_lat_q;
            mv_d      = 1'b1;
            timeout_d = 1'b0;
            locked_d  = (cnt_q == base_period_q) && (hi_lat_q == base_high_q);
          end
          base_period_d = cnt_q;
          base_high_d   = hi_lat_q;
        end else begin
          cnt_d = cnt_inc;
          if (edge_fall) begin
            hi_lat_d = cnt_q;
          end
          if (cnt_inc == CntSat) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any partial measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hi_lat_q      <= '0;
      period_q      <= '0;
      high_q        <= '0;
      base_period_q <= '0;
      base_high_q   <= '0;
      mv_q          <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_lat_q      <= hi_lat_d;
      period_q      <= period_d;
      high_q        <= high_d;
      base_period_q <= base_period_d;
      base_high_q   <= base_high_d;
      mv_q          <= mv_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// Self-checking bench for clk_div_meter (CNT_W=4, SYNC_STAGES=3).
module tb_clk_div_meter;

  localparam int unsigned W   = 4;
  localparam int unsigned S   = 3;
  localparam int unsigned SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  clk_div_meter #(
    .CNT_W      (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]  cyc;
    logic         is_to;
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic         lk;
    logic         to;
  } ev_t;

  ev_t         obs[$];
  ev_t         exp_q[$];
  bit          lvl_log[$];
  int unsigned log_base = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned wide_pulses = 0;
  logic        mv_prev = 1'b0;
  logic        to_prev = 1'b0;

  // Event monitor: every report and every rising timeout, stamped with the clk edge index.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) obs.push_back('{cyc, 1'b0, period, high_time, locked, timeout});
    if (timeout === 1'b1 && to_prev !== 1'b1) obs.push_back('{cyc, 1'b1, period, high_time, locked, timeout});
    if (meas_valid === 1'b1 && mv_prev === 1'b1) wide_pulses++;
    mv_prev = meas_valid;
    to_prev = timeout;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Reference model: walk the sampled levels since reset and derive reports from edge times.
  // A level sampled at edge e acts at edge e+S+1.
  function automatic void build_model(input int unsigned upto);
    int unsigned st = 0;
    int unsigned r = 0, hi = 0, bp = 0, bh = 0, lp = 0, lh = 0;
    bit lk = 1'b0;
    exp_q.delete();
    for (int unsigned i = 0; i < lvl_log.size(); i++) begin
      bit cur, pv;
      int unsigned t;
      cur = lvl_log[i];
      pv  = (i == 0) ? 1'b0 : lvl_log[i-1];
      t   = log_base + i + S + 1;
      if (t > upto) break;
      if (cur && !pv) begin
        if (st == 0) st = 1;
        else if (st == 1) begin bp = t - r; bh = hi; st = 2; end
        else begin
          lp = t - r; lh = hi;
          lk = (lp == bp) && (lh == bh);
          bp = lp; bh = lh;
          exp_q.push_back('{t, 1'b0, W'(lp), W'(lh), lk, 1'b0});
        end
        r = t;
      end else if (st != 0) begin
        if (!cur && pv) hi = t - r;
        if (t - r == SAT - 1) begin
          lk = 1'b0; st = 0;
          exp_q.push_back('{t, 1'b1, W'(lp), W'(lh), 1'b0, 1'b1});
        end
      end
    end
  endfunction

  task automatic step(input bit v);
    @(posedge clk);
    #1 sig_in = v;
    lvl_log.push_back(v);
  endtask

  task automatic wave(input int unsigned p, input int unsigned h, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      for (int unsigned j = 0; j < p; j++) step(j < h);
    end
  endtask

  task automatic rst_on();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_off();
    rst = 1'b0;
    obs.delete();
    lvl_log.delete();
    log_base = cyc + 1;
    lvl_log.push_back(sig_in);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) step(i[0]);
    rst_on();
    vectors++; if (period !== '0) begin miscompares++; $display("FAIL reset_period: got %0d, expected 0", period); end
    vectors++; if (high_time !== '0) begin miscompares++; $display("FAIL reset_high: got %0d, expected 0", high_time); end
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mv: got %b, expected 0", meas_valid); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b, expected 0", locked); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b, expected 0", timeout); end
    rst_off();
  endtask

  task automatic test_steady();
    step(0); step(0);
    wave(6, 3, 6);
    @(negedge clk); #1;
    build_model(cyc);
    vectors++;
    if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL steady_count: got %0d events, expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL steady_ev%0d: got cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b, expected cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b", i,
                 obs[i].cyc, obs[i].is_to, obs[i].p, obs[i].h, obs[i].lk, obs[i].to, exp_q[i].cyc, exp_q[i].is_to, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].to);
      end
    end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL steady_locked: got %b, expected 1", locked); end
  endtask

  task automatic test_switch();
    wave(5, 2, 4);
    @(negedge clk); #1;
    build_model(cyc);
    vectors++;
    if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL switch_count: got %0d events, expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL switch_ev%0d: got cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b, expected cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b", i,
                 obs[i].cyc, obs[i].is_to, obs[i].p, obs[i].h, obs[i].lk, obs[i].to, exp_q[i].cyc, exp_q[i].is_to, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].to);
      end
    end
  endtask

  task automatic test_random();
    int unsigned p, h, n;
    wave(14, 7, 3);
    wave(2, 1, 4);
    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(14, 2);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(4, 2);
      wave(p, h, n);
    end
    @(negedge clk); #1;
    build_model(cyc);
    vectors++;
    if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL random_count: got %0d events, expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_ev%0d: got cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b, expected cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b", i,
                 obs[i].cyc, obs[i].is_to, obs[i].p, obs[i].h, obs[i].lk, obs[i].to, exp_q[i].cyc, exp_q[i].is_to, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].to);
      end
    end
  endtask

  task automatic test_timeout();
    rst_on();
    rst_off();
    step(0); step(0);
    wave(6, 3, 3);
    for (int i = 0; i < 24; i++) step(1);
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_set: got %b, expected 1", timeout); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL timeout_locked: got %b, expected 0", locked); end
    vectors++; if (period !== W'(6)) begin miscompares++; $display("FAIL timeout_period_hold: got %0d, expected 6", period); end
    step(0); step(0);
    wave(4, 2, 4);
    @(negedge clk); #1;
    build_model(cyc);
    vectors++;
    if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL timeout_count: got %0d events, expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL timeout_ev%0d: got cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b, expected cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b", i,
                 obs[i].cyc, obs[i].is_to, obs[i].p, obs[i].h, obs[i].lk, obs[i].to, exp_q[i].cyc, exp_q[i].is_to, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].to);
      end
    end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %b, expected 0", timeout); end
    vectors++; if (high_time !== W'(2)) begin miscompares++; $display("FAIL timeout_restart_high: got %0d, expected 2", high_time); end
  endtask

  task automatic test_mid_reset();
    rst_on();
    rst_off();
    step(0);
    wave(8, 4, 3);
    step(1); step(1); step(1);
    rst_on();
    vectors++; if ({period, high_time} !== '0) begin miscompares++; $display("FAIL midrst_values: got p=%0d h=%0d, expected 0/0", period, high_time); end
    vectors++; if ({meas_valid, locked, timeout} !== 3'b000) begin miscompares++; $display("FAIL midrst_flags: got %b, expected 000", {meas_valid, locked, timeout}); end
    rst_off();
    step(1);
    for (int i = 0; i < 4; i++) step(0);
    wave(8, 4, 3);
    @(negedge clk); #1;
    build_model(cyc);
    vectors++;
    if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL midrst_count: got %0d events, expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      vectors++;
      if (obs[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midrst_ev%0d: got cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b, expected cyc=%0d to=%b p=%0d h=%0d lk=%b tmo=%b", i,
                 obs[i].cyc, obs[i].is_to, obs[i].p, obs[i].h, obs[i].lk, obs[i].to, exp_q[i].cyc, exp_q[i].is_to, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].to);
      end
    end
  endtask

  task automatic test_async();
    int unsigned off;
    rst_on();
    sig_in = 1'b0;
    rst_off();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      off = $urandom_range(9, 1);
      #(off) sig_in = 1'b1;
      #10 sig_in = 1'b0;
      repeat (5) @(posedge clk);
    end
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (obs.size() < 9) begin miscompares++; $display("FAIL async_count: got %0d reports, expected at least 9", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      vectors++;
      if (obs[i].is_to !== 1'b0 || obs[i].p < W'(6) || obs[i].p > W'(8) || obs[i].h !== W'(1)) begin
        miscompares++;
        $display("FAIL async_rep%0d: got to=%b p=%0d h=%0d, expected report with p in 6..8 and h=1", i, obs[i].is_to, obs[i].p, obs[i].h);
      end
    end
    vectors++;
    if (wide_pulses != 0) begin miscompares++; $display("FAIL mv_width: got %0d multi-cycle pulses, expected 0", wide_pulses); end
  endtask

  task automatic test_latency();
    int unsigned e;
    bit hit, early;
    rst_on();
    rst_off();
    step(0);
    wave(4, 2, 3);
    step(1);
    e = cyc + 1;
    step(1); step(0); step(0); step(0); step(0);
    @(negedge clk); #1;
    hit = 1'b0;
    early = 1'b0;
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i].is_to == 1'b0 && obs[i].cyc == e + S + 1) hit = 1'b1;
      if (obs[i].cyc == e + S) early = 1'b1;
    end
    vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL latency_hit: got no report at edge %0d, expected one", e + S + 1); end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL latency_early: got report at edge %0d, expected none", e + S); end
    vectors++; if (period !== W'(4) || high_time !== W'(2)) begin miscompares++; $display("FAIL latency_value: got %0d/%0d, expected 4/2", period, high_time); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_switch();
    test_random();
    test_timeout();
    test_mid_reset();
    test_async();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
